// File: rtl/vga_timing_out.sv
// VGA raster generator and pixel output stage.
// Counts the raster, hands the coordinates to the drawing pipeline, and
// re-aligns the returned RRRGGGBB colour with delayed sync/blank flags
// before driving the DAC pins from flops.
module vga_timing_out #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int RGB_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelEn,
  input  logic [7:0]  inRGB,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        inFrame,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  // Sync/active flags carried down the alignment pipeline.
  typedef struct packed {
    logic hs;   // active-low horizontal sync
    logic vs;   // active-low vertical sync
    logic act;  // inside the visible area
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  logic [10:0] h_count_q, h_count_d;
  logic [10:0] v_count_q, v_count_d;
  logic        sof_q, sof_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_n_q, blank_n_d;
  logic [7:0]  vga_r_q, vga_r_d;
  logic [7:0]  vga_g_q, vga_g_d;
  logic [7:0]  vga_b_q, vga_b_d;

  sync_t raw;
  sync_t tap;

  // Raster counters: advance one pixel per tick, wrap at line and frame end.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pixelEn) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 11'd1;
      end else begin
        h_count_d = h_count_q + 11'd1;
      end
    end
  end

  // Counter registers; reset wins over pixelEn.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Raw, undelayed sync and active flags for the current coordinates.
  always_comb begin
    raw.hs  = !((h_count_q >= HS_FIRST) && (h_count_q <= HS_LAST));
    raw.vs  = !((v_count_q >= VS_FIRST) && (v_count_q <= VS_LAST));
    raw.act = (h_count_q < H_ACT) && (v_count_q < V_ACT);
  end

  // Delay the flags by the drawing pipeline's latency.
  generate
    if (RGB_LATENCY == 0) begin : g_direct
      assign tap = raw;
    end else begin : g_pipe
      sync_t pipe_q [RGB_LATENCY];
      sync_t pipe_d [RGB_LATENCY];

      // Shift one stage per pixel tick.
      always_comb begin
        pipe_d = pipe_q;
        if (pixelEn) begin
          pipe_d[0] = raw;
          for (int i = 1; i < RGB_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
      end

      // Pipeline stages; reset flushes them to blank with syncs inactive.
      always_ff @(posedge clk) begin
        // NOTE: this delay line is reset (unlike a data memory) because
        // stale entries would otherwise reach the sync pins after reset.
        if (reset) begin
          for (int i = 0; i < RGB_LATENCY; i++) begin
            pipe_q[i] <= SYNC_IDLE;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign tap = pipe_q[RGB_LATENCY-1];
    end
  endgenerate

  // Output stage: capture colour with the aligned flags, expand to 8 bits
  // per channel by bit replication, and force black outside the active area.
  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    vga_r_d   = vga_r_q;
    vga_g_d   = vga_g_q;
    vga_b_d   = vga_b_q;
    sof_d     = pixelEn && (h_count_q == '0) && (v_count_q == '0);
    if (pixelEn) begin
      hsync_d   = tap.hs;
      vsync_d   = tap.vs;
      blank_n_d = tap.act;
      if (tap.act) begin
        vga_r_d = {inRGB[7:5], inRGB[7:5], inRGB[7:6]};
        vga_g_d = {inRGB[4:2], inRGB[4:2], inRGB[4:3]};
        vga_b_d = {inRGB[1:0], inRGB[1:0], inRGB[1:0], inRGB[1:0]};
      end else begin
        vga_r_d = '0;
        vga_g_d = '0;
        vga_b_d = '0;
      end
    end
  end

  // Output registers feeding the DAC pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      vga_r_q   <= '0;
      vga_g_q   <= '0;
      vga_b_q   <= '0;
      sof_q     <= 1'b0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      vga_r_q   <= vga_r_d;
      vga_g_q   <= vga_g_d;
      vga_b_q   <= vga_b_d;
      sof_q     <= sof_d;
    end
  end

  assign pixelX       = h_count_q;
  assign pixelY       = v_count_q;
  assign inFrame      = raw.act;
  assign startOfFrame = sof_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign blankN       = blank_n_q;
  assign vgaR         = vga_r_q;
  assign vgaG         = vga_g_q;
  assign vgaB         = vga_b_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out on a reduced raster.
// The stimulus process predicts each cycle's outputs from the raster rules
// (tick count -> position -> coordinates) and queues them; the monitor pops
// one entry per clock and compares.
module tb_vga_timing_out;

  localparam int HA  = 20;
  localparam int HF  = 4;
  localparam int HS  = 6;
  localparam int HB  = 5;
  localparam int VA  = 10;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int LAT = 2;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;

  logic        clk;
  logic        reset;
  logic        pixelEn;
  logic [7:0]  inRGB;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        inFrame;
  logic        startOfFrame;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        hSync;
  logic        vSync;
  logic        blankN;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .RGB_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .pixelEn(pixelEn), .inRGB(inRGB),
    .pixelX(pixelX), .pixelY(pixelY), .inFrame(inFrame),
    .startOfFrame(startOfFrame), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .hSync(hSync), .vSync(vSync), .blankN(blankN)
  );

  typedef struct {
    int x;
    int y;
    bit infr;
    bit sof;
    bit hs;
    bit vs;
    bit bn;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 0;

  // Model state: ticks since the last reset and the last predicted outputs.
  int   ticks = 0;
  exp_t last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_state();
    exp_t e;
    e.x = 0; e.y = 0; e.infr = 1; e.sof = 0;
    e.hs = 1; e.vs = 1; e.bn = 0; e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  // Outputs after the j-th pixel tick since reset, given the colour
  // presented during that tick.
  function automatic exp_t tick_model(input int j, input logic [7:0] c);
    exp_t e;
    int p, k, ox, oy;
    bit act;
    p      = j % FT;
    e.x    = p % HT;
    e.y    = p / HT;
    e.infr = (e.x < HA) && (e.y < VA);
    e.sof  = ((j - 1) % FT) == 0;
    k      = j - 1 - LAT;
    if (k < 0) begin
      e.hs = 1; e.vs = 1; e.bn = 0; e.r = 0; e.g = 0; e.b = 0;
    end else begin
      ox   = (k % FT) % HT;
      oy   = (k % FT) / HT;
      act  = (ox < HA) && (oy < VA);
      e.hs = !(ox >= HA + HF && ox < HA + HF + HS);
      e.vs = !(oy >= VA + VF && oy < VA + VF + VS);
      e.bn = act;
      // 3-bit channels scale to 0..255 by rounding c*255/7; 2-bit by c*85.
      e.r  = act ? (int'(c[7:5]) * 510 + 7) / 14 : 0;
      e.g  = act ? (int'(c[4:2]) * 510 + 7) / 14 : 0;
      e.b  = act ? int'(c[1:0]) * 85 : 0;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the outputs it should produce.
  task automatic cycle(input bit rst, input bit en, input logic [7:0] rgb);
    @(negedge clk);
    reset   = rst;
    pixelEn = en;
    inRGB   = rgb;
    if (rst) begin
      ticks = 0;
      last  = reset_state();
    end else if (en) begin
      ticks++;
      last = tick_model(ticks, rgb);
    end else begin
      last.sof = 0;
    end
    q_exp.push_back(last);
  endtask

  // Stimulus.
  initial begin
    reset   = 1'b1;
    pixelEn = 1'b1;
    inRGB   = 8'h00;
    last    = reset_state();

    for (int i = 0; i < 3; i++) cycle(1, 1, 8'($urandom));

    // Free-running raster: fixed 101_011_10, then white, then random colour.
    for (int i = 0; i < 3 * FT; i++) begin
      if (i < FT)          cycle(0, 1, 8'b101_011_10);
      else if (i < 2 * FT) cycle(0, 1, 8'hFF);
      else                 cycle(0, 1, 8'($urandom));
    end

    // Run to a mid-frame position and reset there.
    for (int i = 0; i < FT && (ticks % FT) != (5 * HT + 13); i++) cycle(0, 1, 8'($urandom));
    cycle(1, 1, 8'($urandom));
    for (int i = 0; i < FT + 50; i++) cycle(0, 1, 8'($urandom));

    // pixelEn toggling every other clock.
    for (int i = 0; i < 2 * FT + 10; i++) cycle(0, i[0], 8'($urandom));

    // Random enables with occasional resets (reset also with pixelEn low).
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) == 0), 1'($urandom), 8'($urandom));
    end

    done = 1;
  end

  // Monitor: one queued expectation per clock, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("pixelX",       32'(pixelX),       32'(e.x));
        check("pixelY",       32'(pixelY),       32'(e.y));
        check("inFrame",      32'(inFrame),      32'(e.infr));
        check("startOfFrame", 32'(startOfFrame), 32'(e.sof));
        check("hSync",        32'(hSync),        32'(e.hs));
        check("vSync",        32'(vSync),        32'(e.vs));
        check("blankN",       32'(blankN),       32'(e.bn));
        check("vgaR",         32'(vgaR),         32'(e.r));
        check("vgaG",         32'(vgaG),         32'(e.g));
        check("vgaB",         32'(vgaB),         32'(e.b));
      end
    end
  end

  // Summary once stimulus is exhausted and the last entry has been checked.
  initial begin
    wait (done);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
